// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch controller.
// Holds one fetched word for decode and drops stale reads after a redirect.
module fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic [15:0] ir_nextpc,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } state_t;

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] irpc_q, irpc_d;
  logic [15:0] irn_q, irn_d;
  logic [7:0]  drop_q, drop_d;
  logic [15:0] target;
  logic [7:0]  drop_inc;

  assign target   = {redirect_pc[15:1], 1'b0};
  assign drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      irpc_q  <= '0;
      irn_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      irn_q   <= irn_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    irpc_d  = irpc_q;
    irn_d   = irn_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (mem_ready) begin
            drop_d = drop_inc;
          end else begin
            // freeze the in-flight address so the bus stays stable
            addr_d  = pc_q;
            state_d = DROP;
          end
        end else if (mem_ready) begin
          ir_d    = mem_rdata;
          irpc_d  = pc_q;
          irn_d   = pc_q + STEP;
          pc_d    = pc_q + STEP;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          drop_d  = drop_inc;
          state_d = FETCH;
        end else if (ir_ready && !stall) begin
          state_d = FETCH;
        end
      end
      DROP: begin
        if (redirect) pc_d = target;
        if (mem_ready) begin
          drop_d  = drop_inc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = (state_q == FETCH) || (state_q == DROP);
  assign mem_addr   = (state_q == DROP) ? addr_q : pc_q;
  assign ir_valid   = (state_q == HOLD);
  assign ir         = ir_q;
  assign ir_pc      = irpc_q;
  assign ir_nextpc  = irn_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, reset cases,
// and a randomized run against a transaction-level reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, mem_ready, ir_ready;
  logic [15:0] redirect_pc, mem_rdata;
  logic        mem_req, ir_valid;
  logic [15:0] mem_addr, ir, ir_pc, ir_nextpc;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_controller dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_nextpc  (ir_nextpc),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        mr;
    logic [15:0] rdata;
    logic        irr;
    logic        req;
    logic [15:0] addr;
    logic        v;
    logic [15:0] eir;
    logic [15:0] epc;
    logic [15:0] enpc;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req,
                         input logic [15:0] addr, input logic v,
                         input logic [15:0] eir, input logic [15:0] epc,
                         input logic [15:0] enpc, input logic [7:0] d);
    chk({tag, ".mem_req"}, {15'd0, mem_req}, {15'd0, req});
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".ir_valid"}, {15'd0, ir_valid}, {15'd0, v});
    chk({tag, ".ir"}, ir, eir);
    chk({tag, ".ir_pc"}, ir_pc, epc);
    chk({tag, ".ir_nextpc"}, ir_nextpc, enpc);
    chk({tag, ".drop_count"}, {8'd0, drop_count}, {8'd0, d});
  endtask

  function automatic vec_t mk(
    input logic st, input logic rd, input logic [15:0] rpc,
    input logic mr, input logic [15:0] rdata, input logic irr,
    input logic req, input logic [15:0] addr, input logic v,
    input logic [15:0] eir, input logic [15:0] epc,
    input logic [15:0] enpc, input logic [7:0] d);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.mr = mr;
    r.rdata = rdata; r.irr = irr; r.req = req; r.addr = addr;
    r.v = v; r.eir = eir; r.epc = epc; r.enpc = enpc; r.d = d;
    return r;
  endfunction

  task automatic idle_inputs();
    stall = 0; redirect = 0; redirect_pc = 0;
    mem_ready = 0; mem_rdata = 0; ir_ready = 0;
  endtask

  // reference model state
  bit          m_started, m_have, m_discard;
  logic [15:0] m_pc, m_out, m_ir, m_irpc, m_irn;
  int          m_drops;

  task automatic model_reset();
    m_started = 0; m_have = 0; m_discard = 0;
    m_pc = 16'h0000; m_out = 16'h0000;
    m_ir = 0; m_irpc = 0; m_irn = 0; m_drops = 0;
  endtask

  task automatic model_step();
    logic [15:0] tgt;
    tgt = redirect_pc & 16'hFFFE;
    if (!m_started) begin
      m_started = 1;
      if (redirect) m_pc = tgt;
    end else if (m_have) begin
      if (redirect) begin
        m_have = 0; m_drops++; m_pc = tgt;
      end else if (ir_ready && !stall) begin
        m_have = 0;
      end
    end else if (m_discard) begin
      if (redirect) m_pc = tgt;
      if (mem_ready) begin
        m_drops++; m_discard = 0;
      end
    end else if (redirect) begin
      if (mem_ready) m_drops++;
      else begin
        m_discard = 1; m_out = m_pc;
      end
      m_pc = tgt;
    end else if (mem_ready) begin
      m_have = 1; m_ir = mem_rdata; m_irpc = m_pc;
      m_irn = 16'((m_pc + 17'd2) % 17'h10000);
      m_pc = m_irn;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 0;

    // table: inputs for one edge, then outputs seen after that edge
    tbl[0]  = mk(0,0,16'h0000,0,16'h0000,1, 1,16'h0000,0,16'h0000,16'h0000,16'h0000,0);
    tbl[1]  = mk(0,0,16'h0000,1,16'hA001,1, 0,16'h0002,1,16'hA001,16'h0000,16'h0002,0);
    tbl[2]  = mk(0,0,16'h0000,0,16'h0000,1, 1,16'h0002,0,16'hA001,16'h0000,16'h0002,0);
    tbl[3]  = mk(0,0,16'h0000,1,16'h1234,0, 0,16'h0004,1,16'h1234,16'h0002,16'h0004,0);
    tbl[4]  = mk(1,0,16'h0000,0,16'h0000,1, 0,16'h0004,1,16'h1234,16'h0002,16'h0004,0);
    tbl[5]  = mk(1,0,16'h0000,0,16'h0000,1, 0,16'h0004,1,16'h1234,16'h0002,16'h0004,0);
    tbl[6]  = mk(1,0,16'h0000,0,16'h0000,1, 0,16'h0004,1,16'h1234,16'h0002,16'h0004,0);
    tbl[7]  = mk(0,0,16'h0000,0,16'h0000,1, 1,16'h0004,0,16'h1234,16'h0002,16'h0004,0);
    tbl[8]  = mk(0,1,16'h0041,0,16'h0000,0, 1,16'h0004,0,16'h1234,16'h0002,16'h0004,0);
    tbl[9]  = mk(0,0,16'h0000,0,16'h0000,0, 1,16'h0004,0,16'h1234,16'h0002,16'h0004,0);
    tbl[10] = mk(0,0,16'h0000,1,16'hDEAD,0, 1,16'h0040,0,16'h1234,16'h0002,16'h0004,1);
    tbl[11] = mk(0,0,16'h0000,1,16'h5555,0, 0,16'h0042,1,16'h5555,16'h0040,16'h0042,1);
    tbl[12] = mk(0,1,16'hFFFE,0,16'h0000,1, 1,16'hFFFE,0,16'h5555,16'h0040,16'h0042,2);
    tbl[13] = mk(0,0,16'h0000,1,16'h7777,0, 0,16'h0000,1,16'h7777,16'hFFFE,16'h0000,2);
    tbl[14] = mk(0,0,16'h0000,0,16'h0000,1, 1,16'h0000,0,16'h7777,16'hFFFE,16'h0000,2);
    tbl[15] = mk(0,1,16'h0100,1,16'hBAD0,0, 1,16'h0100,0,16'h7777,16'hFFFE,16'h0000,3);
    tbl[16] = mk(1,0,16'h0000,0,16'h0000,0, 1,16'h0100,0,16'h7777,16'hFFFE,16'h0000,3);
    tbl[17] = mk(0,1,16'h0200,0,16'h0000,0, 1,16'h0100,0,16'h7777,16'hFFFE,16'h0000,3);
    tbl[18] = mk(0,1,16'h0301,0,16'h0000,0, 1,16'h0100,0,16'h7777,16'hFFFE,16'h0000,3);
    tbl[19] = mk(0,1,16'h0400,1,16'h0000,0, 1,16'h0400,0,16'h7777,16'hFFFE,16'h0000,4);

    #12;
    chk_all("reset", 0, 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_all("idle", 1, 16'h0000, 0, 0, 0, 0, 0);

    // restart from reset so the table begins in IDLE
    rst = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      stall = tbl[i].st; redirect = tbl[i].rd;
      redirect_pc = tbl[i].rpc; mem_ready = tbl[i].mr;
      mem_rdata = tbl[i].rdata; ir_ready = tbl[i].irr;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr,
              tbl[i].v, tbl[i].eir, tbl[i].epc, tbl[i].enpc, tbl[i].d);
    end

    // async reset while a dropped read is outstanding
    idle_inputs();
    redirect = 1; redirect_pc = 16'h0800;
    @(negedge clk);
    idle_inputs();
    chk("drop.mem_addr", mem_addr, 16'h0400);
    chk("drop.mem_req", {15'd0, mem_req}, 16'd1);
    #2;
    rst = 0;
    #1;
    chk_all("async_rst", 0, 16'h0000, 0, 0, 0, 0, 0);
    mem_ready = 1; mem_rdata = 16'hFACE;
    @(negedge clk);
    chk_all("rst_held", 0, 16'h0000, 0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    chk_all("late_ready", 1, 16'h0000, 0, 0, 0, 0, 0);

    // randomized run against the reference model
    idle_inputs();
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      chk_all("rand", m_started && !m_have,
              m_discard ? m_out : m_pc, m_have,
              m_ir, m_irpc, m_irn,
              8'(m_drops > 255 ? 255 : m_drops));
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 3) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                                : 16'($urandom);
      mem_ready   = ($urandom_range(0, 1) == 1);
      mem_rdata   = 16'($urandom);
      ir_ready    = ($urandom_range(0, 1) == 1);
      model_step();
      @(negedge clk);
    end
    chk("saturated", {8'd0, drop_count}, 16'h00FF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 2, meaning the byte increment between sequential 16-bit instructions.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 stall  input  1  pipeline hold; blocks release of the held instruction.
REQ-006 redirect  input  1  branch/jump taken; load redirect_pc.
REQ-007 redirect_pc  input  16  redirect target address.
REQ-008 mem_req  output  1  instruction-memory read request.
REQ-009 mem_addr  output  16  instruction-memory read address.
REQ-010 mem_ready  input  1  memory completed the read this cycle; mem_rdata valid.
REQ-011 mem_rdata  input  16  instruction word from memory.
REQ-012 ir_valid  output  1  ir, ir_pc and ir_nextpc hold a valid instruction.
REQ-013 ir_ready  input  1  decode accepts the instruction this cycle.
REQ-014 ir  output  16  fetched instruction.
REQ-015 ir_pc  output  16  address of ir.
REQ-016 ir_nextpc  output  16  ir_pc + PC_STEP.
REQ-017 drop_count  output  8  number of fetched words discarded due to redirect.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, HOLD and DROP, with at most one memory request outstanding at any time.
REQ-019 IDLE: outputs are inactive; the block SHALL move to FETCH on the first clock edge after reset is released.
REQ-020 FETCH: mem_req=1 and mem_addr=pc. On mem_ready without redirect, the block SHALL latch ir=mem_rdata, ir_pc=pc and ir_nextpc=pc+PC_STEP, set pc to pc+PC_STEP, and move to HOLD.
REQ-021 HOLD: mem_req=0 and ir_valid=1. On ir_ready && !stall, the block SHALL clear ir_valid on the next cycle and move to FETCH; otherwise ir, ir_pc and ir_nextpc SHALL remain stable.
REQ-022 While mem_req=1 and mem_ready=0, mem_addr SHALL NOT change, including when redirect is asserted.
REQ-023 Redirect in FETCH with mem_ready=1: discard mem_rdata, increment drop_count, set pc=redirect_pc, remain in FETCH.
REQ-024 Redirect in FETCH with mem_ready=0: set pc=redirect_pc, move to DROP.
REQ-025 DROP: mem_req=1 and mem_addr=the original outstanding address. On mem_ready, the block SHALL discard the data, increment drop_count, and move to FETCH using the new pc.
REQ-026 Redirect in DROP: pc SHALL take the latest redirect_pc (last one wins). Redirect in DROP on the same cycle as mem_ready: new pc applied and the block moves to FETCH.
REQ-027 Redirect in HOLD, regardless of stall or ir_ready: ir_valid=0 on the next cycle, drop_count increments, pc=redirect_pc, move to FETCH; the held instruction SHALL NOT be counted as accepted.
REQ-028 Redirect has priority over stall, ir_ready and mem_ready in every state; redirect in IDLE loads pc and the block still moves to FETCH.
REQ-029 Redirect targets SHALL have bit 0 forced to 0.
REQ-030 pc arithmetic is modulo 2^16: 16'hFFFE + 2 SHALL equal 16'h0000, and ir_nextpc wraps identically.
REQ-031 drop_count SHALL saturate at 8'hFF.
REQ-032 stall SHALL have no effect in FETCH or DROP; it only holds HOLD.

Reset
REQ-033 While rst=0, asynchronously: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0, ir_nextpc=0, drop_count=0.
REQ-034 Reset asserted mid-request SHALL abandon the request immediately; a late mem_ready in IDLE SHALL be ignored.

Verification
REQ-035 Sequential: release reset, mem_ready one cycle after each mem_req, ir_ready=1 -> mem_addr 0000, 0002, 0004; ir_pc/ir_nextpc pairs 0000/0002, 0002/0004.
REQ-036 Stall: HOLD with ir=16'h1234, stall=1 for 3 cycles with ir_ready=1 -> ir_valid stays 1, ir stable, mem_req=0; release -> next mem_addr=ir_nextpc.
REQ-037 Redirect while waiting: mem_addr=0004, mem_ready=0, redirect to 0041 -> mem_addr held at 0004 until mem_ready, data dropped, drop_count=1, next mem_addr=0040.
REQ-038 Redirect in HOLD with ir_ready=1 -> instruction not accepted, ir_valid=0, next mem_addr=redirect_pc, drop_count increments.
REQ-039 Wrap: redirect to FFFE, fetch it -> ir_nextpc=0000, next mem_addr=0000.
REQ-040 Async reset mid-DROP -> all outputs at reset values immediately, without a clock edge; a subsequent mem_ready is ignored.
